// File: rtl/scandoubler_ctrl_pkg.sv
// Shared types and constants for the scandoubler supervisor: FSM states,
// user mode codes, counter widths and the per-frame timing sample.
package scandoubler_ctrl_pkg;

    localparam int PERIOD_W = 16;
    localparam int COUNT_W  = 12;

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_TRACK  = 2'd1,
        S_SWITCH = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [1:0] SD_OFF      = 2'b00;
    localparam logic [1:0] SD_AUTO     = 2'b01;
    localparam logic [1:0] SD_FORCE    = 2'b10;
    localparam logic [1:0] SD_AUTO_ALT = 2'b11;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [COUNT_W-1:0]  hpix;
        logic [COUNT_W-1:0]  lines;
    } sample_t;

    function automatic logic [PERIOD_W-1:0] period_dist(input logic [PERIOD_W-1:0] a,
                                                        input logic [PERIOD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/scandoubler_ctrl_if.sv
// Video-in / control-out bundle between the core's video output and the
// scandoubler supervisor; master is the video source side.
interface scandoubler_ctrl_if;
    import scandoubler_ctrl_pkg::*;

    logic                ce_pix;
    logic                hs_in;
    logic                vs_in;
    logic                hb_in;
    logic                vb_in;
    logic [1:0]          sd_mode;
    logic                hq2x_req;
    logic                sd_en;
    logic                hq2x_en;
    logic                vid_mute;
    logic                locked;
    logic [PERIOD_W-1:0] line_period;
    logic [COUNT_W-1:0]  h_active;
    logic [COUNT_W-1:0]  v_active;

    modport master (
        output ce_pix, hs_in, vs_in, hb_in, vb_in, sd_mode, hq2x_req,
        input  sd_en, hq2x_en, vid_mute, locked, line_period, h_active, v_active
    );

    modport slave (
        input  ce_pix, hs_in, vs_in, hb_in, vb_in, sd_mode, hq2x_req,
        output sd_en, hq2x_en, vid_mute, locked, line_period, h_active, v_active
    );

endinterface

// File: rtl/vid_timing_meas.sv
// Measures line period, active pixels and active lines of the incoming video
// and presents a frame sample together with a one-cycle vsync strobe.
module vid_timing_meas
    import scandoubler_ctrl_pkg::*;
(
    input  logic    clk_vid,
    input  logic    reset,
    input  logic    i_cePix,
    input  logic    i_hs,
    input  logic    i_vs,
    input  logic    i_hb,
    input  logic    i_vb,
    output logic    o_frameValid,
    output sample_t o_sample,
    output logic    o_watchdog
);

    logic                r_hsQ, r_hsQQ, r_vsQ, r_vsQQ;
    logic [PERIOD_W-1:0] r_periodCnt, r_periodCur;
    logic [COUNT_W-1:0]  r_pixCnt, r_hpixCur, r_lineCnt;

    logic                w_hsRise, w_vsRise, w_lineActive, w_pixInc;
    logic [PERIOD_W-1:0] w_periodInc, w_periodNext;
    logic [COUNT_W-1:0]  w_hpixNext, w_lineNext;

    assign w_hsRise = r_hsQ & ~r_hsQQ;
    assign w_vsRise = r_vsQ & ~r_vsQQ;
    assign w_pixInc = i_cePix & ~i_hb & ~i_vb;

    // The edge cycle itself is counted, so a line of P clocks measures P.
    assign w_periodInc  = (r_periodCnt == '1) ? r_periodCnt : r_periodCnt + 16'd1;
    assign w_lineActive = w_hsRise & (r_pixCnt != '0);
    assign w_periodNext = w_hsRise ? w_periodInc : r_periodCur;
    assign w_hpixNext   = w_lineActive ? r_pixCnt : r_hpixCur;
    assign w_lineNext   = (w_lineActive && (r_lineCnt != '1)) ? r_lineCnt + 12'd1 : r_lineCnt;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_hsQ       <= 1'b0;
            r_hsQQ      <= 1'b0;
            r_vsQ       <= 1'b0;
            r_vsQQ      <= 1'b0;
            r_periodCnt <= '0;
            r_periodCur <= '0;
            r_pixCnt    <= '0;
            r_hpixCur   <= '0;
            r_lineCnt   <= '0;
        end else begin
            r_hsQ       <= i_hs;
            r_hsQQ      <= r_hsQ;
            r_vsQ       <= i_vs;
            r_vsQQ      <= r_vsQ;
            r_periodCnt <= w_hsRise ? '0 : w_periodInc;
            r_periodCur <= w_periodNext;
            r_hpixCur   <= w_hpixNext;
            r_lineCnt   <= w_vsRise ? '0 : w_lineNext;
            if (w_hsRise)
                r_pixCnt <= '0;
            else if (w_pixInc && (r_pixCnt != '1))
                r_pixCnt <= r_pixCnt + 12'd1;
        end
    end

    // Sample uses next-state values so a line ending with vsync is included.
    assign o_frameValid = w_vsRise;
    assign o_sample     = '{period: w_periodNext, hpix: w_hpixNext, lines: w_lineNext};
    assign o_watchdog   = (r_periodCnt == '1);

endmodule

// File: rtl/scandoubler_ctrl.sv
// Scandoubler supervisor: locks onto stable input timing, picks sd/hq2x mode
// and applies mode changes only on vsync edges behind a mute window.
module scandoubler_ctrl
    import scandoubler_ctrl_pkg::*;
#(
    parameter logic [15:0] LOWRATE_THR   = 16'd2400,
    parameter int          PERIOD_TOL    = 4,
    parameter int          STABLE_FRAMES = 3,
    parameter int          MUTE_FRAMES   = 2
) (
    input  logic               clk_vid,
    input  logic               reset,
    scandoubler_ctrl_if.slave  bus
);

    localparam logic [PERIOD_W-1:0] TOL         = 16'(PERIOD_TOL);
    localparam logic [3:0]          STABLE_LAST = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0]          MUTE_LOAD   = 4'(MUTE_FRAMES);

    state_t              r_state, w_stateNext;
    sample_t             r_prevSample, w_sample;
    logic [3:0]          r_stableCnt, w_stableNext, r_muteCnt, w_muteNext;
    logic                r_applied, w_appliedNext;
    logic                r_sdEn, w_sdEnNext, r_hqEn, w_hqEnNext;
    logic [PERIOD_W-1:0] r_linePeriod;
    logic [COUNT_W-1:0]  r_hActive, r_vActive;

    logic                w_fv, w_wd, w_match, w_publish;
    logic                w_wantSd, w_wantHq, w_modeChange, w_autoMode;
    logic [PERIOD_W-1:0] w_periodSel;

    vid_timing_meas u_meas (
        .clk_vid      (clk_vid),
        .reset        (reset),
        .i_cePix      (bus.ce_pix),
        .i_hs         (bus.hs_in),
        .i_vs         (bus.vs_in),
        .i_hb         (bus.hb_in),
        .i_vb         (bus.vb_in),
        .o_frameValid (w_fv),
        .o_sample     (w_sample),
        .o_watchdog   (w_wd)
    );

    assign w_match = (period_dist(w_sample.period, r_prevSample.period) <= TOL)
                   && (w_sample.hpix  == r_prevSample.hpix)
                   && (w_sample.lines == r_prevSample.lines);

    // Target mode follows the sample being taken on a vsync edge, else the last stored one.
    assign w_periodSel  = w_fv ? w_sample.period : r_prevSample.period;
    assign w_autoMode   = (bus.sd_mode == SD_AUTO) || (bus.sd_mode == SD_AUTO_ALT);
    assign w_wantSd     = (bus.sd_mode == SD_FORCE) || (w_autoMode && (w_periodSel > LOWRATE_THR));
    assign w_wantHq     = w_wantSd & bus.hq2x_req;
    assign w_modeChange = (w_wantSd != r_sdEn) || (w_wantHq != r_hqEn);

    always_comb begin
        w_stateNext   = r_state;
        w_stableNext  = r_stableCnt;
        w_muteNext    = r_muteCnt;
        w_appliedNext = r_applied;
        w_sdEnNext    = r_sdEn;
        w_hqEnNext    = r_hqEn;
        w_publish     = 1'b0;
        if (w_wd) begin
            w_stateNext  = S_UNLOCK;
            w_stableNext = '0;
        end else begin
            unique case (r_state)
                S_UNLOCK: begin
                    w_stableNext = '0;
                    if (w_fv)
                        w_stateNext = S_TRACK;
                end
                S_TRACK: begin
                    if (w_fv && !w_match) begin
                        w_stableNext = '0;
                    end else if (w_fv && ((r_stableCnt + 4'd1) >= STABLE_LAST)) begin
                        w_stateNext   = S_SWITCH;
                        w_stableNext  = '0;
                        w_sdEnNext    = w_wantSd;
                        w_hqEnNext    = w_wantHq;
                        w_muteNext    = MUTE_LOAD;
                        w_appliedNext = 1'b1;
                        w_publish     = 1'b1;
                    end else if (w_fv) begin
                        w_stableNext = r_stableCnt + 4'd1;
                    end
                end
                S_SWITCH: begin
                    w_publish = w_fv;
                    if (w_fv && !w_match) begin
                        w_stateNext  = S_TRACK;
                        w_stableNext = '0;
                    end else if (w_fv && !r_applied) begin
                        w_sdEnNext    = w_wantSd;
                        w_hqEnNext    = w_wantHq;
                        w_muteNext    = MUTE_LOAD;
                        w_appliedNext = 1'b1;
                    end else if (w_fv) begin
                        if (r_muteCnt <= 4'd1)
                            w_stateNext = S_RUN;
                        else
                            w_muteNext = r_muteCnt - 4'd1;
                    end else if (w_modeChange) begin
                        w_appliedNext = 1'b0;
                    end
                end
                S_RUN: begin
                    w_publish = w_fv;
                    if (w_fv && !w_match) begin
                        w_stateNext  = S_TRACK;
                        w_stableNext = '0;
                    end else if (w_modeChange) begin
                        w_stateNext   = S_SWITCH;
                        w_appliedNext = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_state      <= S_UNLOCK;
            r_stableCnt  <= '0;
            r_muteCnt    <= '0;
            r_applied    <= 1'b0;
            r_sdEn       <= 1'b0;
            r_hqEn       <= 1'b0;
            r_prevSample <= '0;
            r_linePeriod <= '0;
            r_hActive    <= '0;
            r_vActive    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_stableCnt <= w_stableNext;
            r_muteCnt   <= w_muteNext;
            r_applied   <= w_appliedNext;
            r_sdEn      <= w_sdEnNext;
            r_hqEn      <= w_hqEnNext;
            if (w_fv)
                r_prevSample <= w_sample;
            if (w_publish) begin
                r_linePeriod <= w_sample.period;
                r_hActive    <= w_sample.hpix;
                r_vActive    <= w_sample.lines;
            end
        end
    end

    assign bus.sd_en       = r_sdEn;
    assign bus.hq2x_en     = r_hqEn & r_sdEn;
    assign bus.vid_mute    = (r_state != S_RUN);
    assign bus.locked      = (r_state == S_SWITCH) || (r_state == S_RUN);
    assign bus.line_period = r_linePeriod;
    assign bus.h_active    = r_hActive;
    assign bus.v_active    = r_vActive;

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// Directed bench for scandoubler_ctrl; line periods and the low-rate threshold
// are scaled down so whole frames stay short.
module tb_scandoubler_ctrl;
    import scandoubler_ctrl_pkg::*;

    logic clk_vid = 1'b0;
    logic reset   = 1'b1;
    int   assertCount = 0;
    int   failCount   = 0;

    scandoubler_ctrl_if bus();

    scandoubler_ctrl #(
        .LOWRATE_THR   (16'd100),
        .PERIOD_TOL    (4),
        .STABLE_FRAMES (3),
        .MUTE_FRAMES   (2)
    ) dut (
        .clk_vid (clk_vid),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives cycles [from,to) of one line: hsync (and optional vsync) in cycles 0-7, pixels from cycle 16.
    task automatic applyStimulus(input int period, input int hpix, input bit active,
                                 input bit vsync, input int from, input int to);
        for (int c = from; c < to; c++) begin
            bus.ce_pix = 1'b1;
            bus.hs_in  = (c < 8);
            bus.vs_in  = vsync && (c < 8);
            bus.hb_in  = !(active && (c >= 16) && (c < 16 + hpix));
            bus.vb_in  = !active;
            @(posedge clk_vid);
            #1;
        end
    endtask

    task automatic runFrame(input int period, input int hpix, input int lines);
        for (int l = 0; l < lines; l++)
            applyStimulus(period, hpix, 1'b1, 1'b0, 0, period);
        applyStimulus(period, hpix, 1'b0, 1'b1, 0, period);
    endtask

    task automatic idleCycles(input int n);
        bus.hs_in = 1'b0;
        bus.vs_in = 1'b0;
        bus.hb_in = 1'b1;
        bus.vb_in = 1'b1;
        repeat (n) @(posedge clk_vid);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " sd_en"},       16'(bus.sd_en),    16'd0);
        checkOutput({tag, " hq2x_en"},     16'(bus.hq2x_en),  16'd0);
        checkOutput({tag, " vid_mute"},    16'(bus.vid_mute), 16'd1);
        checkOutput({tag, " locked"},      16'(bus.locked),   16'd0);
        checkOutput({tag, " line_period"}, bus.line_period,   16'd0);
        checkOutput({tag, " h_active"},    16'(bus.h_active), 16'd0);
        checkOutput({tag, " v_active"},    16'(bus.v_active), 16'd0);
    endtask

    initial begin
        bus.ce_pix   = 1'b1;
        bus.hs_in    = 1'b0;
        bus.vs_in    = 1'b0;
        bus.hb_in    = 1'b1;
        bus.vb_in    = 1'b1;
        bus.sd_mode  = SD_AUTO;
        bus.hq2x_req = 1'b1;
        repeat (4) @(posedge clk_vid);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        idleCycles(10);

        // 31 kHz class, auto: lock on third vsync, scandoubler stays off.
        runFrame(64, 40, 3);
        checkOutput("31k f1 locked", 16'(bus.locked), 16'd0);
        runFrame(64, 40, 3);
        checkOutput("31k f2 locked", 16'(bus.locked), 16'd0);
        runFrame(64, 40, 3);
        checkOutput("31k f3 locked",   16'(bus.locked),   16'd1);
        checkOutput("31k f3 mute",     16'(bus.vid_mute), 16'd1);
        checkOutput("31k sd_en",       16'(bus.sd_en),    16'd0);
        checkOutput("31k hq2x_en",     16'(bus.hq2x_en),  16'd0);
        checkOutput("31k line_period", bus.line_period,   16'd64);
        checkOutput("31k h_active",    16'(bus.h_active), 16'd40);
        checkOutput("31k v_active",    16'(bus.v_active), 16'd3);
        runFrame(64, 40, 3);
        checkOutput("31k f4 mute", 16'(bus.vid_mute), 16'd1);
        runFrame(64, 40, 3);
        checkOutput("31k f5 mute",   16'(bus.vid_mute), 16'd0);
        checkOutput("31k f5 locked", 16'(bus.locked),   16'd1);

        // Reset in the middle of a locked frame, then finish the partial frame.
        applyStimulus(64, 40, 1'b1, 1'b0, 0, 64);
        applyStimulus(64, 40, 1'b1, 1'b0, 0, 64);
        reset = 1'b1;
        @(posedge clk_vid);
        #1;
        reset = 1'b0;
        checkResetValues("midreset");
        applyStimulus(64, 40, 1'b1, 1'b0, 0, 64);
        applyStimulus(64, 40, 1'b0, 1'b1, 0, 64);
        checkOutput("partial locked", 16'(bus.locked), 16'd0);

        // 15 kHz class, auto with hq2x: mode applied exactly on the locking vsync.
        runFrame(128, 80, 3);
        checkOutput("15k g1 locked", 16'(bus.locked), 16'd0);
        runFrame(128, 80, 3);
        checkOutput("15k g2 locked", 16'(bus.locked), 16'd0);
        for (int l = 0; l < 3; l++)
            applyStimulus(128, 80, 1'b1, 1'b0, 0, 128);
        applyStimulus(128, 80, 1'b0, 1'b1, 0, 1);
        checkOutput("15k pre-edge locked", 16'(bus.locked), 16'd0);
        checkOutput("15k pre-edge sd_en",  16'(bus.sd_en),  16'd0);
        applyStimulus(128, 80, 1'b0, 1'b1, 1, 2);
        checkOutput("15k edge locked",  16'(bus.locked),   16'd1);
        checkOutput("15k edge sd_en",   16'(bus.sd_en),    16'd1);
        checkOutput("15k edge hq2x_en", 16'(bus.hq2x_en),  16'd1);
        checkOutput("15k edge mute",    16'(bus.vid_mute), 16'd1);
        applyStimulus(128, 80, 1'b0, 1'b1, 2, 128);
        checkOutput("15k line_period", bus.line_period,   16'd128);
        checkOutput("15k h_active",    16'(bus.h_active), 16'd80);
        checkOutput("15k v_active",    16'(bus.v_active), 16'd3);
        runFrame(128, 80, 3);
        checkOutput("15k g4 mute", 16'(bus.vid_mute), 16'd1);
        runFrame(128, 80, 3);
        checkOutput("15k g5 mute", 16'(bus.vid_mute), 16'd0);

        // Period jitter up to the tolerance keeps lock and republishes the period.
        runFrame(131, 80, 3);
        checkOutput("jit131 locked", 16'(bus.locked), 16'd1);
        checkOutput("jit131 period", bus.line_period, 16'd131);
        runFrame(128, 80, 3);
        checkOutput("jit128 period", bus.line_period, 16'd128);
        runFrame(132, 80, 3);
        checkOutput("jit132 locked", 16'(bus.locked),   16'd1);
        checkOutput("jit132 mute",   16'(bus.vid_mute), 16'd0);
        checkOutput("jit132 period", bus.line_period,   16'd132);
        runFrame(128, 80, 3);
        checkOutput("jit back locked", 16'(bus.locked), 16'd1);

        // One frame with an extra active line drops lock on the cycle after its vsync edge.
        for (int l = 0; l < 4; l++)
            applyStimulus(128, 80, 1'b1, 1'b0, 0, 128);
        applyStimulus(128, 80, 1'b0, 1'b1, 0, 1);
        checkOutput("mis pre-edge locked", 16'(bus.locked), 16'd1);
        applyStimulus(128, 80, 1'b0, 1'b1, 1, 2);
        checkOutput("mis edge locked", 16'(bus.locked),   16'd0);
        checkOutput("mis edge mute",   16'(bus.vid_mute), 16'd1);
        checkOutput("mis edge sd_en",  16'(bus.sd_en),    16'd1);
        applyStimulus(128, 80, 1'b0, 1'b1, 2, 128);
        runFrame(128, 80, 3);
        checkOutput("relock h1 locked", 16'(bus.locked), 16'd0);
        runFrame(128, 80, 3);
        checkOutput("relock h2 locked", 16'(bus.locked), 16'd0);
        runFrame(128, 80, 3);
        checkOutput("relock h3 locked", 16'(bus.locked), 16'd1);
        runFrame(128, 80, 3);
        runFrame(128, 80, 3);
        checkOutput("relock h5 mute", 16'(bus.vid_mute), 16'd0);

        // Hsync stops: watchdog fires once the period counter saturates.
        idleCycles(65300);
        checkOutput("wd before locked", 16'(bus.locked),   16'd1);
        checkOutput("wd before mute",   16'(bus.vid_mute), 16'd0);
        idleCycles(200);
        checkOutput("wd locked",  16'(bus.locked),   16'd0);
        checkOutput("wd mute",    16'(bus.vid_mute), 16'd1);
        checkOutput("wd sd_en",   16'(bus.sd_en),    16'd1);
        checkOutput("wd hq2x_en", 16'(bus.hq2x_en),  16'd1);

        // Relock, then switch the user mode off mid-frame.
        runFrame(128, 80, 3);
        runFrame(128, 80, 3);
        runFrame(128, 80, 3);
        checkOutput("k3 locked", 16'(bus.locked), 16'd1);
        runFrame(128, 80, 3);
        runFrame(128, 80, 3);
        checkOutput("k5 mute", 16'(bus.vid_mute), 16'd0);
        applyStimulus(128, 80, 1'b1, 1'b0, 0, 20);
        bus.sd_mode = SD_OFF;
        applyStimulus(128, 80, 1'b1, 1'b0, 20, 21);
        checkOutput("user mute",   16'(bus.vid_mute), 16'd1);
        checkOutput("user sd_en",  16'(bus.sd_en),    16'd1);
        checkOutput("user locked", 16'(bus.locked),   16'd1);
        applyStimulus(128, 80, 1'b1, 1'b0, 21, 128);
        applyStimulus(128, 80, 1'b1, 1'b0, 0, 128);
        applyStimulus(128, 80, 1'b1, 1'b0, 0, 128);
        applyStimulus(128, 80, 1'b0, 1'b1, 0, 1);
        checkOutput("user pre-edge sd_en", 16'(bus.sd_en), 16'd1);
        applyStimulus(128, 80, 1'b0, 1'b1, 1, 2);
        checkOutput("user edge sd_en",   16'(bus.sd_en),    16'd0);
        checkOutput("user edge hq2x_en", 16'(bus.hq2x_en),  16'd0);
        checkOutput("user edge mute",    16'(bus.vid_mute), 16'd1);
        applyStimulus(128, 80, 1'b0, 1'b1, 2, 128);
        runFrame(128, 80, 3);
        checkOutput("user +1 mute", 16'(bus.vid_mute), 16'd1);
        runFrame(128, 80, 3);
        checkOutput("user +2 mute",  16'(bus.vid_mute), 16'd0);
        checkOutput("user +2 sd_en", 16'(bus.sd_en),    16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/scandoubler_ctrl.md
Name: scandoubler_ctrl

Overview:
- Supervises the scandoubler: measures incoming video timing and decides when it is stable.
- Selects scandoubler enable and hq2x based on line rate and user request.
- Sequences mode changes so outputs switch only at frame boundaries, with a forced-blank (mute) window around every switch.
- Sits between the core's video output and the scandoubler in the clk_vid domain; drives the scandoubler's hq2x input and the downstream bypass mux / blanking gate.

Parameters:
- LOWRATE_THR, 16'd2400: line period in clk_vid cycles above which the input counts as 15 kHz class (strictly greater than).
- PERIOD_TOL, 4: allowed frame-to-frame difference of the line period, in clk_vid cycles.
- STABLE_FRAMES, 3: consecutive matching frames required before lock.
- MUTE_FRAMES, 2: frames of forced blank after a mode switch is applied.

Ports:
- clk_vid  in  1  video clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  input pixel enable.
- hs_in  in  1  input hsync, active high.
- vs_in  in  1  input vsync, active high.
- hb_in  in  1  input hblank.
- vb_in  in  1  input vblank.
- sd_mode  in  2  user request: 00 off, 01 auto, 10 force on, 11 treated as 01.
- hq2x_req  in  1  user hq2x request.
- sd_en  out  1  scandoubler path selected.
- hq2x_en  out  1  hq2x drive to scandoubler; forced 0 whenever sd_en=0.
- vid_mute  out  1  force-blank downstream video.
- locked  out  1  timing stable.
- line_period  out  16  last measured line period, in clk_vid cycles.
- h_active  out  12  active pixels per line.
- v_active  out  12  active lines per frame.

Behaviour:
- Reset values: sd_en=0, hq2x_en=0, vid_mute=1, locked=0, line_period=0, h_active=0, v_active=0, FSM in S_UNLOCK.
- Edge detection: hs/vs rising edges come from 1-cycle registered copies. Every edge event is 1 clk late relative to the pin.
- Line period counter: 16-bit, increments every clk and saturates at 0xFFFF. On an hs rising edge it latches into period_cur and clears to 0.
- Pixel counter: 12-bit, saturating. Increments on ce_pix & ~hb_in & ~vb_in. On an hs rising edge, a nonzero value is latched into hpix_cur and sets line_active; the counter then clears.
- Line counter: 12-bit, saturating. Increments on an hs rising edge when line_active was set.
- Frame sample: taken on each vs rising edge.
  - Sample is {period_cur, hpix_cur, line count}; the line count then clears.
  - The sample matches the previous one if |period difference| <= PERIOD_TOL and h/v counts are exactly equal.
  - Published outputs (line_period, h_active, v_active) update only on a vs edge while locked, or on the edge that sets lock.
- Watchdog: if the line period counter reaches 0xFFFF (no hsync), go to S_UNLOCK immediately: locked=0, vid_mute=1.
- Target mode, combinational from the latest sample:
  - want_sd = (sd_mode==10) | ((sd_mode==01|sd_mode==11) & period>LOWRATE_THR).
  - want_hq = want_sd & hq2x_req.
- FSM:
  - S_UNLOCK: mute=1, locked=0, stable_cnt=0. Any vs edge → S_TRACK.
  - S_TRACK: mute=1. Each vs edge: a match increments stable_cnt; a mismatch clears it to 0. When stable_cnt reaches STABLE_FRAMES-1 on a match → locked=1, S_SWITCH.
  - S_SWITCH: apply sd_en<=want_sd and hq2x_en<=want_hq on the same vs edge that enters or is next seen. Load mute_cnt=MUTE_FRAMES; each later vs edge decrements it; at 0 → S_RUN.
  - S_RUN: mute=0. A vs edge with a sample mismatch → S_TRACK with locked=0 and mute=1 on the next cycle. sd_en/hq2x_en are held. A change of want_sd or want_hq (user change) → S_SWITCH with mute=1 the next cycle; the new mode is applied only at the next vs edge.
- Simultaneous events:
  - Watchdog has priority over every other transition.
  - Mismatch has priority over a user change.
  - hs and vs edges in the same cycle: the line is counted before the frame sample is taken.
- sd_en and hq2x_en never change outside a vs rising edge, except by reset.
- Reset mid-frame: all counters clear and the first partial frame is discarded (S_UNLOCK→S_TRACK only on a vs edge).

Decomposition:
- Package scandoubler_ctrl_pkg:
  - FSM state encoding (S_UNLOCK, S_TRACK, S_SWITCH, S_RUN).
  - sd_mode constants.
  - Counter widths (16/12).
- One sub-module, vid_timing_meas: edge detection, the three counters, watchdog, and sample/strobe output (frame_valid pulse plus sample).
- FSM and mode logic stay in the top level.

Test Plan:
- 15 kHz, auto mode: period 3200 clk, 320×240, sd_mode=01, hq2x_req=1 → locked=1 at the 3rd vs edge; sd_en=1 and hq2x_en=1 switch on that edge; vid_mute falls 2 vs edges later; line_period=3200, h_active=320, v_active=240.
- 31 kHz, auto mode: period 1600 → sd_en=0 and hq2x_en=0 despite hq2x_req=1; lock and mute timing as above.
- Jitter and mismatch: period alternating 3200/3203 → stays locked. A single frame with v_active 241 → locked=0 and mute=1 the cycle after that vs edge; relock after 3 clean frames.
- User change in S_RUN: sd_mode 01→00 mid-frame → mute=1 next cycle; sd_en stays 1 until the next vs edge, then 0; mute releases 2 frames later.
- Watchdog: hs stopped for 65535 clk → locked=0, mute=1, S_UNLOCK; sd_en held.
- Reset asserted mid-frame while locked → all outputs return to reset values the next cycle; the partial frame is ignored.
